// File: rtl/mux_pkg.sv
// Shared parameters and index helpers for the round-robin stream multiplexer.
package mux_pkg;

  localparam int unsigned DEFAULT_W = 8;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Next channel index after idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, grant gated by advance.
module rr_arbiter import mux_pkg::*; #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  int unsigned cand;
  logic        found;

  // Scan ptr, ptr+1, ... with modulo-N wrap; ptr is always below N.
  always_comb begin
    cand    = 32'd0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[SEL_W'(cand)]) begin
        found   = 1'b1;
        gnt_idx = SEL_W'(cand);
      end
    end
  end

  assign gnt = (advance && found) ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/rr_mux_n.sv
// N-channel round-robin stream mux with one registered output stage.
// Define RRMUX_LOCK_EN to keep the grant on a channel until its in_last beat.
module rr_mux_n import mux_pkg::*; #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = DEFAULT_W,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
`ifdef RRMUX_LOCK_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_d;
  logic [W-1:0]     out_data_d;
  logic [SEL_W-1:0] out_sel_d;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             load_en;
  logic             xfer;
  logic [W-1:0]     ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_data[i] = in_data[i*W +: W];
  end

  assign load_en = !out_valid || out_ready;

`ifdef RRMUX_LOCK_EN
  logic             locked_q, locked_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             out_last_d;

  // While mid-packet only the owning channel may be granted.
  assign req = locked_q ? (in_valid & (N'(1) << lock_ch_q)) : in_valid;
`else
  assign req = in_valid;
`endif

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .advance (load_en && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;
  assign xfer     = |gnt;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sel_d   = out_sel;
`ifdef RRMUX_LOCK_EN
    locked_d    = locked_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[gnt_idx];
      out_sel_d   = gnt_idx;
`ifdef RRMUX_LOCK_EN
      out_last_d  = in_last[gnt_idx];
      if (in_last[gnt_idx]) begin
        ptr_d    = SEL_W'(wrap_inc(32'(gnt_idx), N));
        locked_d = 1'b0;
      end else begin
        locked_d  = 1'b1;
        lock_ch_d = gnt_idx;
      end
`else
      ptr_d = SEL_W'(wrap_inc(32'(gnt_idx), N));
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
`ifdef RRMUX_LOCK_EN
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
      out_last  <= 1'b0;
`endif
    end else begin
      ptr_q     <= ptr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sel   <= out_sel_d;
`ifdef RRMUX_LOCK_EN
      locked_q  <= locked_d;
      lock_ch_q <= lock_ch_d;
      out_last  <= out_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Self-checking bench for rr_mux_n: vector table plus a scoreboard of accepted beats.
module tb_rr_mux_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  logic [2:0]  v3, rdy3;
  logic [23:0] d3;
  logic        ov3, r3;
  logic [7:0]  od3;
  logic [1:0]  os3;

`ifdef RRMUX_LOCK_EN
  logic [3:0] in_last;
  logic       out_last;
  logic [2:0] last3;
  logic       ol3;
`endif

  rr_mux_n #(.N(4), .W(8)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RRMUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_mux_n #(.N(3), .W(8)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v3),
    .in_data   (d3),
`ifdef RRMUX_LOCK_EN
    .in_last   (last3),
    .out_last  (ol3),
`endif
    .in_ready  (rdy3),
    .out_valid (ov3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_ready (r3)
  );

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    logic       last;
  } beat_t;

  beat_t sb[$];
  vec_t  tbl[19];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle on the N=4 instance: drive, check handshake and output, track accepted beats.
  task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] last,
                      input logic [3:0] exp_rdy, input logic exp_ov, input string tag);
    beat_t b;
    @(negedge clk);
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(32'hA0 + i + 16*cyc);
`ifdef RRMUX_LOCK_EN
    in_last = last;
`endif
    #1;
    chk($sformatf("%s.in_ready", tag), 32'(in_ready), 32'(exp_rdy));
    chk($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      if (sb.size() == 0) begin
        chk($sformatf("%s.sb_underflow", tag), 32'(sb.size()), 32'd1);
      end else begin
        chk($sformatf("%s.out_data", tag), 32'(out_data), 32'(sb[0].data));
        chk($sformatf("%s.out_sel", tag), 32'(out_sel), 32'(sb[0].sel));
`ifdef RRMUX_LOCK_EN
        chk($sformatf("%s.out_last", tag), 32'(out_last), 32'(sb[0].last));
`endif
        if (rdy) void'(sb.pop_front());
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        b.data = 8'(32'hA0 + i + 16*cyc);
        b.sel  = 2'(i);
        b.last = last[i];
        sb.push_back(b);
      end
    end
    cyc++;
  endtask

  initial begin
    // rotation
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1};
    // backpressure then resume with the next channel
    tbl[5]  = '{4'hF, 1'b0, 4'b0000, 1'b1};
    tbl[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1};
    tbl[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1};
    tbl[8]  = '{4'hF, 1'b1, 4'b0010, 1'b1};
    // ptr reaches 3, lone request on channel 1 wraps, then drain
    tbl[9]  = '{4'hF, 1'b1, 4'b0100, 1'b1};
    tbl[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    // idle does not rotate ptr (still 2), so channel 3 wins over 0 and 1
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[14] = '{4'b1011, 1'b0, 4'b1000, 1'b0};
    tbl[15] = '{4'b1011, 1'b0, 4'b0000, 1'b1};
    tbl[16] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b0;
    in_data   = '0;
    v3        = '0;
    r3        = 1'b0;
    d3        = {8'h32, 8'h31, 8'h30};
`ifdef RRMUX_LOCK_EN
    in_last   = 4'hF;
    last3     = 3'b111;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_sel", 32'(out_sel), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.n3_out_valid", 32'(ov3), 32'd0);
    @(negedge clk);
    in_valid = 4'h0;
    rst_n    = 1'b1;

    for (int i = 0; i < 19; i++)
      step(tbl[i].v, tbl[i].rdy, 4'hF, tbl[i].exp_rdy, tbl[i].exp_ov, $sformatf("row%0d", i));

    // Reset while the output register is full.
    step(4'hF, 1'b1, 4'hF, 4'b0010, 1'b0, "pre_rst");
    @(negedge clk);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    chk("midrst.out_sel", 32'(out_sel), 32'd0);
    chk("midrst.out_data", 32'(out_data), 32'd0);
    sb.delete();
    @(negedge clk);
    in_valid = 4'h0;
    rst_n    = 1'b1;
    step(4'h0, 1'b1, 4'hF, 4'b0000, 1'b0, "post_rst0");
    step(4'hF, 1'b1, 4'hF, 4'b0001, 1'b0, "post_rst1");
    step(4'h0, 1'b1, 4'hF, 4'b0000, 1'b1, "post_rst2");

`ifdef RRMUX_LOCK_EN
    // Channel 2 packet of three beats holds off channel 0.
    step(4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, "lock0");
    step(4'b0101, 1'b1, 4'b0000, 4'b0100, 1'b1, "lock1");
    step(4'b0101, 1'b1, 4'b0100, 4'b0100, 1'b1, "lock2");
    step(4'b0001, 1'b1, 4'hF,    4'b0001, 1'b1, "lock3");
    step(4'b0000, 1'b1, 4'hF,    4'b0000, 1'b1, "lock4");
`endif

    // N=3 instance: grants cycle 0,1,2 and out_sel never reaches 3.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      v3 = 3'b111;
      r3 = 1'b1;
      #1;
      chk($sformatf("n3.k%0d.in_ready", k), 32'(rdy3), 32'(1 << (k % 3)));
      chk($sformatf("n3.k%0d.out_valid", k), 32'(ov3), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk($sformatf("n3.k%0d.out_sel", k), 32'(os3), 32'((k - 1) % 3));
        chk($sformatf("n3.k%0d.out_data", k), 32'(od3), 32'(32'h30 + (k - 1) % 3));
      end
    end
    @(negedge clk);
    v3 = 3'b000;
    @(negedge clk);
    #1;
    chk("n3.drain", 32'(ov3), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
